// File: rtl/set_scan.sv
// Grid scanner: walks every (x,y) point, counts those matching a set expression.
// Define SCAN_PIPE_EN to register covered_i before accumulation (adds DRAIN).
module set_scan #(
   parameter int GRID_MAX = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [23:0] central_i,
   input  logic [11:0] radius_i,
   input  logic [1:0]  mode_i,
   output logic [23:0] cent_buf_o,
   output logic [11:0] r_buf_o,
   output logic [7:0]  coord_o,
   input  logic [2:0]  covered_i,
   output logic        busy_o,
   output logic        valid_o,
   output logic [7:0]  candidate_o
);

   localparam logic [3:0] GMAX = 4'(GRID_MAX);

`ifdef SCAN_PIPE_EN
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
`endif

   state_t      state_q;
   logic [23:0] cent_q;
   logic [11:0] rad_q;
   logic [1:0]  mode_q;
   logic [3:0]  x_q;
   logic [3:0]  y_q;
   logic [7:0]  cnt_q;
   logic        busy_q;
   logic        valid_q;

   logic [2:0]  acc_cov_d;
   logic        acc_en_d;
   logic        hit_d;
   logic        last_d;

`ifdef SCAN_PIPE_EN
   logic [2:0]  cov_q;
   logic        pv_q;

   assign acc_cov_d = cov_q;
   assign acc_en_d  = pv_q;
`else
   assign acc_cov_d = covered_i;
   assign acc_en_d  = (state_q == SCAN);
`endif

   // acc_cov_d bit order: [2]=A, [1]=B, [0]=C
   always_comb begin
      hit_d = 1'b0;
      unique case (mode_q)
         2'b00: hit_d = acc_cov_d[2];
         2'b01: hit_d = acc_cov_d[2] & acc_cov_d[1];
         2'b10: hit_d = acc_cov_d[2] ^ acc_cov_d[1];
         2'b11: hit_d = (acc_cov_d == 3'b110) ||
                        (acc_cov_d == 3'b101) ||
                        (acc_cov_d == 3'b011);
      endcase
   end

   assign last_d = (x_q == GMAX) && (y_q == GMAX);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cent_q  <= '0;
         rad_q   <= '0;
         mode_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
`ifdef SCAN_PIPE_EN
         cov_q   <= '0;
         pv_q    <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         if (acc_en_d && hit_d)
            cnt_q <= cnt_q + 8'd1;
`ifdef SCAN_PIPE_EN
         cov_q <= covered_i;
         pv_q  <= (state_q == SCAN);
`endif
         unique case (state_q)
            IDLE: begin
               if (en_i) begin
                  cent_q  <= central_i;
                  rad_q   <= radius_i;
                  mode_q  <= mode_i;
                  cnt_q   <= '0;
                  x_q     <= 4'd1;
                  y_q     <= 4'd1;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (last_d) begin
`ifdef SCAN_PIPE_EN
                  state_q <= DRAIN;
`else
                  state_q <= DONE;
                  valid_q <= 1'b1;
`endif
               end else if (x_q == GMAX) begin
                  x_q <= 4'd1;
                  y_q <= y_q + 4'd1;
               end else begin
                  x_q <= x_q + 4'd1;
               end
            end
`ifdef SCAN_PIPE_EN
            DRAIN: begin
               state_q <= DONE;
               valid_q <= 1'b1;
            end
`endif
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cent_buf_o  = cent_q;
   assign r_buf_o     = rad_q;
   assign coord_o     = {x_q, y_q};
   assign busy_o      = busy_q;
   assign valid_o     = valid_q;
   assign candidate_o = cnt_q;

endmodule

// File: tb/tb_set_scan.sv
// Self-checking bench for set_scan with a behavioural distance PE and count model.
// Honours SCAN_PIPE_EN for the expected result latency.
module tb_set_scan;

   localparam int N  = 8;
   localparam int NN = N * N;
`ifdef SCAN_PIPE_EN
   localparam int LAT = NN + 1;
`else
   localparam int LAT = NN;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [23:0] central = '0;
   logic [11:0] radius = '0;
   logic [1:0]  mode = '0;
   logic [23:0] cent_buf;
   logic [11:0] r_buf;
   logic [7:0]  coord;
   logic [2:0]  covered;
   logic        busy;
   logic        valid;
   logic [7:0]  cand;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   set_scan #(.GRID_MAX(N)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en),
      .central_i(central), .radius_i(radius), .mode_i(mode),
      .cent_buf_o(cent_buf), .r_buf_o(r_buf), .coord_o(coord),
      .covered_i(covered), .busy_o(busy), .valid_o(valid),
      .candidate_o(cand)
   );

   function automatic bit in_c(int x, int y, int cx, int cy, int r);
      return (x - cx) * (x - cx) + (y - cy) * (y - cy) <= r * r;
   endfunction

   // Distance PE: pure function of the point and the latched circles
   always_comb begin
      covered = '0;
      covered[2] = in_c(int'(coord[7:4]), int'(coord[3:0]),
                        int'(cent_buf[23:20]), int'(cent_buf[19:16]), int'(r_buf[11:8]));
      covered[1] = in_c(int'(coord[7:4]), int'(coord[3:0]),
                        int'(cent_buf[15:12]), int'(cent_buf[11:8]), int'(r_buf[7:4]));
      covered[0] = in_c(int'(coord[7:4]), int'(coord[3:0]),
                        int'(cent_buf[7:4]), int'(cent_buf[3:0]), int'(r_buf[3:0]));
   end

   function automatic int ref_count(logic [23:0] c, logic [11:0] r, logic [1:0] m);
      int n = 0;
      for (int y = 1; y <= N; y++)
         for (int x = 1; x <= N; x++) begin
            int a, b, k;
            bit e;
            a = in_c(x, y, int'(c[23:20]), int'(c[19:16]), int'(r[11:8]));
            b = in_c(x, y, int'(c[15:12]), int'(c[11:8]), int'(r[7:4]));
            k = in_c(x, y, int'(c[7:4]), int'(c[3:0]), int'(r[3:0]));
            case (m)
               2'd0: e = (a == 1);
               2'd1: e = (a == 1) && (b == 1);
               2'd2: e = (a != b);
               default: e = (a + b + k) == 2;
            endcase
            if (e) n++;
         end
      return n;
   endfunction

   task automatic chk_zero(input string nm);
      checks++;
      if ({coord, cent_buf, r_buf, cand, busy, valid} !== '0) begin
         errors++;
         $display("FAIL %s: coord=%h cent=%h r=%h cand=%0d busy=%b valid=%b required all 0",
                  nm, coord, cent_buf, r_buf, cand, busy, valid);
      end
   endtask

   task automatic do_run(input logic [23:0] c, input logic [11:0] r,
                         input logic [1:0] m, input int exp,
                         input bit hold_en, input bit scramble, input string nm);
      int n;
      int idx;
      bit seen;
      logic [7:0] ec;
      @(negedge clk);
      central = c; radius = r; mode = m; en = 1'b1;
      @(posedge clk);
      #1;
      if (!hold_en) en = 1'b0;
      n = 0;
      seen = 0;
      while (n <= LAT + 3) begin
         @(negedge clk);
         idx = (n < NN) ? n : NN - 1;
         ec = {4'(idx % N + 1), 4'(idx / N + 1)};
         checks++;
         if (coord !== ec) begin
            errors++;
            $display("FAIL %s coord step %0d: got %h required %h", nm, n, coord, ec);
         end
         if (scramble && n == 5) begin
            central = $urandom; radius = $urandom; mode = $urandom;
         end
         if (valid) begin
            seen = 1;
            break;
         end
         n++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: no valid_o within %0d cycles", nm, LAT + 3);
         return;
      end
      checks++;
      if (n != LAT) begin
         errors++;
         $display("FAIL %s latency: got %0d required %0d", nm, n, LAT);
      end
      checks++;
      if (cand !== 8'(exp)) begin
         errors++;
         $display("FAIL %s count: got %0d required %0d", nm, cand, exp);
      end
      checks++;
      if (cent_buf !== c || r_buf !== r || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s buffers: cent=%h r=%h busy=%b required %h %h 1",
                  nm, cent_buf, r_buf, busy, c, r);
      end
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || cand !== 8'(exp) || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s post: valid=%b cand=%0d busy=%b required 0 %0d 0",
                  nm, valid, cand, busy, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_zero("reset_state");
      rst = 1'b0;
      @(negedge clk);
      chk_zero("reset_release_idle");
   endtask

   task automatic test_directed();
      do_run({4'd4, 4'd4, 8'h00, 8'h00}, 12'h200, 2'b00, 13, 0, 0, "single_A");
      do_run({4'd4, 4'd4, 4'd4, 4'd4, 8'h00}, 12'h220, 2'b01, 13, 0, 0, "A_and_B");
      do_run({4'd4, 4'd4, 4'd4, 4'd4, 8'h00}, 12'h220, 2'b10, 0, 0, 0, "A_xor_B");
      do_run({4'd4, 4'd4, 4'd4, 4'd4, 4'd8, 4'd8}, 12'h221, 2'b11, 13, 0, 0, "two_of_three");
      do_run({4'd3, 4'd3, 16'h0000}, 12'h000, 2'b00, 1, 0, 0, "zero_radius");
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         logic [23:0] c;
         logic [11:0] r;
         logic [1:0]  m;
         c = $urandom;
         r = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6))};
         m = 2'($urandom);
         do_run(c, r, m, ref_count(c, r, m), 0, i[0], $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] c;
      logic [11:0] r;
      int pulses;
      c = {4'd2, 4'd5, 4'd6, 4'd3, 4'd1, 4'd1};
      r = 12'h343;
      do_run(c, r, 2'b11, ref_count(c, r, 2'b11), 1, 1, "held_en");
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || cand !== 8'd0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL held_en restart: busy=%b cand=%0d valid=%b required 1 0 0",
                  busy, cand, valid);
      end
      en = 1'b0;
      pulses = 0;
      repeat (LAT + 4) begin
         @(negedge clk);
         if (valid) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL held_en pulses: got %0d required 1", pulses);
      end
   endtask

   task automatic test_mid_reset();
      int pulses;
      @(negedge clk);
      central = {4'd4, 4'd4, 16'h0}; radius = 12'h300; mode = 2'b00; en = 1'b1;
      @(posedge clk);
      #1 en = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero("mid_reset_async");
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (LAT + 3) begin
         @(negedge clk);
         if (valid || busy) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL mid_reset activity: got %0d active cycles required 0", pulses);
      end
      chk_zero("mid_reset_idle");
      do_run({4'd4, 4'd4, 8'h00, 8'h00}, 12'h200, 2'b00, 13, 0, 0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
